uart_cmd_controller: RTL and testbench

//  Sequencer between the UART RX FIFO interface and the TX FIFO interface.

---
 rtl/uart_cmd_controller.sv | 122 ++++++++++++
 tb/tb_uart_cmd_controller.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_controller.sv
// Command sequencer between the UART RX FIFO and TX FIFO: echoes ordinary bytes,
// answers the trigger byte with a hex snapshot of Value_In (optionally CR LF terminated).
module uart_cmd_controller #(
    parameter logic [7:0] TRIG_CHAR = 8'h54,
    parameter int          DATA_W    = 24,
    parameter bit          HEX_UPPER = 1'b1,
    parameter bit          ADD_CRLF  = 1'b1
) (
    input  logic              CLK,
    input  logic              RSTn,
    input  logic              Empty_Sig,
    input  logic [7:0]        FIFO_Read_Data,
    output logic              Read_Req_Sig,
    input  logic              Full_Sig,
    output logic [7:0]        FIFO_Write_Data,
    output logic              Write_Req_Sig,
    input  logic [DATA_W-1:0] Value_In,
    output logic              Busy_Sig,
    output logic [7:0]        Cmd_Count,
    output logic [3:0]        dbg_state
);

    localparam int NDIG  = DATA_W / 4;
    localparam int IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NDIG - 1);

    typedef enum logic [3:0] {
        IDLE    = 4'd0,
        RD_REQ  = 4'd1,
        RD_WAIT = 4'd2,
        DECODE  = 4'd3,
        ECHO    = 4'd4,
        HEX     = 4'd5,
        CR      = 4'd6,
        LF      = 4'd7,
        DONE    = 4'd8
    } state_t;

    // Handshake: Read_Req_Sig is a one-cycle pop, data is taken the following cycle.
    // Write_Req_Sig is high whenever a byte is pending and the TX FIFO is not full;
    // every cycle it is high at a rising edge the byte is consumed and the FSM advances.

    state_t           state, state_nxt;
    logic [7:0]       rx_byte;
    logic [DATA_W-1:0] snapshot;
    logic [IDX_W-1:0] digit_idx;
    logic [7:0]       cmd_count;
    logic [3:0]       nibble;
    logic [7:0]       hex_char;
    logic             write_state;

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            state     <= IDLE;
            rx_byte   <= 8'h00;
            snapshot  <= '0;
            digit_idx <= '0;
            cmd_count <= 8'h00;
        end else begin
            state <= state_nxt;
            if (state == RD_WAIT)
                rx_byte <= FIFO_Read_Data;
            if (state == DECODE && rx_byte == TRIG_CHAR) begin
                snapshot  <= Value_In;
                digit_idx <= LAST_IDX;
            end
            if (state == HEX && Write_Req_Sig && digit_idx != '0)
                digit_idx <= digit_idx - 1'b1;
            if (state == DONE)
                cmd_count <= cmd_count + 8'd1;
        end
    end

    always_comb begin
        nibble = snapshot[{digit_idx, 2'b00} +: 4];
        if (nibble < 4'd10)
            hex_char = 8'h30 + {4'h0, nibble};
        else
            hex_char = (HEX_UPPER ? 8'h37 : 8'h57) + {4'h0, nibble};
    end

    assign write_state = (state == ECHO) || (state == HEX) || (state == CR) || (state == LF);

    // Gated by RSTn so that a reset cycle never pops or pushes a byte.
    assign Write_Req_Sig = RSTn && write_state && !Full_Sig;
    assign Read_Req_Sig  = RSTn && (state == RD_REQ);

    always_comb begin
        state_nxt       = state;
        FIFO_Write_Data = 8'h00;
        case (state)
            IDLE:    if (!Empty_Sig) state_nxt = RD_REQ;
            RD_REQ:  state_nxt = RD_WAIT;
            RD_WAIT: state_nxt = DECODE;
            DECODE:  state_nxt = (rx_byte == TRIG_CHAR) ? HEX : ECHO;
            ECHO: begin
                FIFO_Write_Data = rx_byte;
                if (Write_Req_Sig) state_nxt = IDLE;
            end
            HEX: begin
                FIFO_Write_Data = hex_char;
                if (Write_Req_Sig && digit_idx == '0)
                    state_nxt = ADD_CRLF ? CR : DONE;
            end
            CR: begin
                FIFO_Write_Data = 8'h0D;
                if (Write_Req_Sig) state_nxt = LF;
            end
            LF: begin
                FIFO_Write_Data = 8'h0A;
                if (Write_Req_Sig) state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign Busy_Sig  = (state != IDLE);
    assign Cmd_Count = cmd_count;
    assign dbg_state = state;

endmodule

// File: tb/tb_uart_cmd_controller.sv
// Bench for uart_cmd_controller: RX/TX FIFO models, byte scoreboard, vector table,
// hand-written corner sequences and randomized traffic with TX back-pressure.
module tb_uart_cmd_controller;

    logic        CLK = 1'b0;
    logic        RSTn;
    logic        Empty_Sig;
    logic [7:0]  FIFO_Read_Data;
    logic        Read_Req_Sig;
    logic        Full_Sig;
    logic [7:0]  FIFO_Write_Data;
    logic        Write_Req_Sig;
    logic [23:0] Value_In;
    logic        Busy_Sig;
    logic [7:0]  Cmd_Count;
    logic [3:0]  dbg_state;

    uart_cmd_controller dut (
        .CLK(CLK), .RSTn(RSTn), .Empty_Sig(Empty_Sig), .FIFO_Read_Data(FIFO_Read_Data),
        .Read_Req_Sig(Read_Req_Sig), .Full_Sig(Full_Sig), .FIFO_Write_Data(FIFO_Write_Data),
        .Write_Req_Sig(Write_Req_Sig), .Value_In(Value_In), .Busy_Sig(Busy_Sig),
        .Cmd_Count(Cmd_Count), .dbg_state(dbg_state)
    );

    // ---------------- clock / reset
    always #5 CLK = ~CLK;

    // ---------------- bench state
    int          checks = 0;
    int          errors = 0;
    logic [7:0]  rx_q[$];
    logic [7:0]  exp_q[$];
    logic [7:0]  wr_log[$];
    int          cyc = 0;
    int          read_total = 0;
    int          fall_cyc = 0;
    int          rd_cyc = -1;
    int          wr_cyc = -1;
    int          busy_cnt = 0;
    bit          rand_full = 1'b0;
    bit          stall_armed = 1'b0;
    int          stall_at = 0;
    int          stall_left = 0;
    logic [7:0]  model_cmd = 8'h00;

    typedef struct {
        logic [7:0]  rx;
        logic [23:0] val;
        int          exp_len;
        logic [7:0]  exp_first;
        logic [7:0]  exp_last;
        int          exp_inc;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #2;
    endtask

    // Reference: trigger -> six uppercase hex digits MSB first, then CR LF; else echo.
    task automatic model_push(input logic [7:0] b, input logic [23:0] v);
        if (b == 8'h54) begin
            for (int d = 5; d >= 0; d--) begin
                int n;
                n = int'((v >> (4 * d)) & 24'hF);
                exp_q.push_back(n < 10 ? 8'(48 + n) : 8'(65 + n - 10));
            end
            exp_q.push_back(8'h0D);
            exp_q.push_back(8'h0A);
            model_cmd = model_cmd + 8'd1;
        end else begin
            exp_q.push_back(b);
        end
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (!(rx_q.size() == 0 && exp_q.size() == 0 && Busy_Sig == 1'b0) && n < budget) begin
            tick(1);
            n++;
        end
        checks++;
        if (n >= budget) begin
            errors++;
            $display("FAIL idle_timeout: state %0d, rx left %0d, expected bytes left %0d, required idle within %0d cycles",
                     dbg_state, rx_q.size(), exp_q.size(), budget);
            rx_q.delete();
            exp_q.delete();
        end
    endtask

    // ---------------- FIFO models and write monitor (negative edge)
    initial begin
        Empty_Sig      = 1'b1;
        Full_Sig       = 1'b0;
        FIFO_Read_Data = 8'h00;
        forever begin
            @(negedge CLK);
            cyc++;
            if (stall_left > 0) begin
                Full_Sig = 1'b1;
                stall_left--;
            end else if (stall_armed && wr_log.size() == stall_at) begin
                Full_Sig    = 1'b1;
                stall_left  = 9;
                stall_armed = 1'b0;
            end else begin
                Full_Sig = rand_full && ($urandom_range(0, 3) == 0);
            end
            #1;
            if (Full_Sig) check("no_write_when_full", Write_Req_Sig, 1'b0);
            if (Write_Req_Sig) begin
                wr_log.push_back(FIFO_Write_Data);
                if (wr_cyc < 0) wr_cyc = cyc;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: got 0x%0h, expected no write", FIFO_Write_Data);
                end else begin
                    check("write_data", FIFO_Write_Data, exp_q.pop_front());
                end
            end
            if (Read_Req_Sig) begin
                read_total++;
                if (rd_cyc < 0) rd_cyc = cyc;
                if (rx_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL read_on_empty: got a pop, expected none");
                end else begin
                    FIFO_Read_Data = rx_q.pop_front();
                end
            end
            if (Busy_Sig) busy_cnt++;
            if (Empty_Sig && rx_q.size() != 0) begin
                fall_cyc = cyc;
                rd_cyc   = -1;
                wr_cyc   = -1;
                busy_cnt = 0;
            end
            Empty_Sig = (rx_q.size() == 0);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence
    initial begin
        vec_t        vecs[8];
        logic [7:0]  rep[8];
        int          base, rd_base, hold, n;
        logic [7:0]  cmd_base;
        logic [7:0]  b;
        logic [23:0] v;

        vecs[0] = '{8'h61, 24'h000000, 1, 8'h61, 8'h61, 0};
        vecs[1] = '{8'h54, 24'h12AB3F, 8, 8'h31, 8'h0A, 1};
        vecs[2] = '{8'h74, 24'hABCDEF, 1, 8'h74, 8'h74, 0};
        vecs[3] = '{8'h54, 24'hFFFFFF, 8, 8'h46, 8'h0A, 1};
        vecs[4] = '{8'h54, 24'h000000, 8, 8'h30, 8'h0A, 1};
        vecs[5] = '{8'h0D, 24'h123456, 1, 8'h0D, 8'h0D, 0};
        vecs[6] = '{8'h54, 24'hA00009, 8, 8'h41, 8'h0A, 1};
        vecs[7] = '{8'h00, 24'h654321, 1, 8'h00, 8'h00, 0};
        rep = '{8'h31, 8'h32, 8'h41, 8'h42, 8'h33, 8'h46, 8'h0D, 8'h0A};

        RSTn     = 1'b0;
        Value_In = 24'h0;
        tick(3);
        RSTn = 1'b1;
        #1;
        check("rst_read_req", Read_Req_Sig, 1'b0);
        check("rst_write_req", Write_Req_Sig, 1'b0);
        check("rst_write_data", FIFO_Write_Data, 8'h00);
        check("rst_busy", Busy_Sig, 1'b0);
        check("rst_cmd_count", Cmd_Count, 8'h00);

        // Vector table, FIFO never full: content, length, latency, busy span.
        for (int i = 0; i < 8; i++) begin
            base     = wr_log.size();
            cmd_base = Cmd_Count;
            Value_In = vecs[i].val;
            model_push(vecs[i].rx, vecs[i].val);
            rx_q.push_back(vecs[i].rx);
            wait_idle(200);
            check("vec_len", wr_log.size() - base, vecs[i].exp_len);
            if (wr_log.size() > base) begin
                check("vec_first", wr_log[base], vecs[i].exp_first);
                check("vec_last", wr_log[wr_log.size() - 1], vecs[i].exp_last);
            end
            check("vec_cmd", Cmd_Count, 8'(cmd_base + vecs[i].exp_inc));
            check("vec_read_latency", rd_cyc - fall_cyc, 1);
            check("vec_write_latency", wr_cyc - fall_cyc, 4);
            check("vec_busy_cycles", busy_cnt, (vecs[i].exp_len == 1) ? 4 : 12);
            check("vec_busy_after", Busy_Sig, 1'b0);
        end

        // Full_Sig held 10 cycles at the third digit.
        base     = wr_log.size();
        cmd_base = Cmd_Count;
        Value_In = 24'h12AB3F;
        foreach (rep[k]) exp_q.push_back(rep[k]);
        model_cmd   = model_cmd + 8'd1;
        stall_at    = base + 2;
        stall_armed = 1'b1;
        rx_q.push_back(8'h54);
        wait_idle(200);
        check("stall_taken", stall_armed, 1'b0);
        check("stall_len", wr_log.size() - base, 8);
        check("stall_cmd", Cmd_Count, 8'(cmd_base + 1));

        // Value_In changes right after DECODE; reply keeps the snapshot.
        base     = wr_log.size();
        Value_In = 24'h12AB3F;
        foreach (rep[k]) exp_q.push_back(rep[k]);
        model_cmd = model_cmd + 8'd1;
        rx_q.push_back(8'h54);
        tick(4);
        Value_In = 24'h000000;
        wait_idle(200);
        check("snap_len", wr_log.size() - base, 8);

        // Three queued bytes: 'x', 'T', 't'.
        base     = wr_log.size();
        rd_base  = read_total;
        cmd_base = Cmd_Count;
        Value_In = 24'h12AB3F;
        model_push(8'h78, Value_In);
        model_push(8'h54, Value_In);
        model_push(8'h74, Value_In);
        rx_q.push_back(8'h78);
        rx_q.push_back(8'h54);
        rx_q.push_back(8'h74);
        wait_idle(300);
        check("multi_len", wr_log.size() - base, 10);
        check("multi_reads", read_total - rd_base, 3);
        check("multi_cmd", Cmd_Count, 8'(cmd_base + 1));

        // Randomized bytes and values with random TX back-pressure.
        rand_full = 1'b1;
        for (int i = 0; i < 40; i++) begin
            b = ($urandom_range(0, 2) == 0) ? 8'h54 : 8'($urandom_range(0, 255));
            v = 24'($urandom);
            Value_In = v;
            model_push(b, v);
            rx_q.push_back(b);
            tick(6);
            Value_In = 24'($urandom);
            wait_idle(400);
            check("rand_cmd", Cmd_Count, model_cmd);
        end
        rand_full = 1'b0;
        tick(2);

        // Reset in the middle of a report.
        base     = wr_log.size();
        Value_In = 24'h12AB3F;
        foreach (rep[k]) exp_q.push_back(rep[k]);
        rx_q.push_back(8'h54);
        n = 0;
        while (wr_log.size() < base + 3 && n < 50) begin
            tick(1);
            n++;
        end
        check("midreport_reached", n < 50, 1'b1);
        RSTn = 1'b0;
        exp_q.delete();
        tick(1);
        RSTn = 1'b1;
        #1;
        check("midrst_read_req", Read_Req_Sig, 1'b0);
        check("midrst_write_req", Write_Req_Sig, 1'b0);
        check("midrst_write_data", FIFO_Write_Data, 8'h00);
        check("midrst_busy", Busy_Sig, 1'b0);
        check("midrst_cmd", Cmd_Count, 8'h00);
        model_cmd = 8'h00;
        hold = wr_log.size();
        tick(6);
        check("no_write_after_reset", wr_log.size() - hold, 0);
        base = wr_log.size();
        model_push(8'h54, Value_In);
        rx_q.push_back(8'h54);
        wait_idle(200);
        check("post_reset_len", wr_log.size() - base, 8);
        check("post_reset_cmd", Cmd_Count, 8'h01);

        // 255 more reports wrap the counter from 1 back to 0.
        base     = wr_log.size();
        Value_In = 24'h00BEEF;
        for (int i = 0; i < 255; i++) begin
            model_push(8'h54, Value_In);
            rx_q.push_back(8'h54);
        end
        wait_idle(255 * 14 + 100);
        check("wrap_len", wr_log.size() - base, 255 * 8);
        check("wrap_cmd", Cmd_Count, 8'h00);
        check("wrap_busy", Busy_Sig, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
